// File: rtl/uart_delay_cmd_packer.sv
// uart_delay_cmd_packer: queues delay-RAM write requests and packs each one
// into a 64-bit UART_RX_DATA frame, handing frames to UART_TX_DATA one per
// transfer with an acknowledge timeout and an enforced inter-frame gap.
module uart_delay_cmd_packer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        I_clk_10M,
  input  logic        I_rst,
  input  logic        I_wr_vld,
  output logic        O_wr_rdy,
  input  logic [4:0]  I_awg_id,
  input  logic [1:0]  I_port,
  input  logic [10:0] I_addr,
  input  logic [23:0] I_delay,
  output logic [63:0] O_UART_DATA,
  output logic        O_UART_DATA_VLD,
  input  logic        I_tx_ready,
  output logic        O_busy,
  output logic [15:0] O_frame_cnt,
  output logic        O_tx_err
);

  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   ACK_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]    SYNC     = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  // XOR of every frame byte except the checksum byte itself.
  function automatic logic [7:0] f_checksum(input logic [63:0] frame);
    f_checksum = frame[63:56] ^ frame[55:48] ^ frame[47:40] ^ frame[39:32]
               ^ frame[23:16] ^ frame[15:8]  ^ frame[7:0];
  endfunction

  // Queue entry {awg_id, port, addr, delay} -> wire frame.
  function automatic logic [63:0] f_pack(input logic [41:0] entry);
    logic [63:0] frame;
    frame = {SYNC, entry[41:37], entry[36:35], 6'd0, entry[34:24], 8'd0, entry[23:0]};
    frame[31:24] = f_checksum(frame);
    f_pack = frame;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [41:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [15:0]   r_cnt;
  logic          r_wr_rdy;
  logic [63:0]   r_data;
  logic          r_vld;
  logic          r_busy;
  logic [15:0]   r_frame_cnt;
  logic          r_tx_err;
  logic          w_push;
  logic          w_pop;
  logic          w_fire;
  logic          w_timeout;

  // O_wr_rdy is the registered "not full", so a pop in the same cycle never lets a full queue accept.
  assign w_push      = I_wr_vld & r_wr_rdy;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign O_wr_rdy        = r_wr_rdy;
  assign O_UART_DATA     = r_data;
  assign O_UART_DATA_VLD = r_vld;
  assign O_busy          = r_busy;
  assign O_frame_cnt     = r_frame_cnt;
  assign O_tx_err        = r_tx_err;

  // Next-state and per-cycle strobes. LOAD already samples I_tx_ready so the
  // registered VLD can rise on the same edge that loads the frame; SEND is the
  // holding state while UART_TX_DATA is not ready.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fire      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != {CW{1'b0}}) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_pop = (r_count != {CW{1'b0}});
        if (I_tx_ready) begin
          w_fire      = 1'b1;
          w_state_nxt = S_WAIT_LOW;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (I_tx_ready) begin
          w_fire      = 1'b1;
          w_state_nxt = S_WAIT_LOW;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_WAIT_LOW: begin
        if (!I_tx_ready) begin
          w_state_nxt = S_WAIT_HIGH;
        end else if (r_cnt == ACK_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_WAIT_LOW;
        end
      end
      S_WAIT_HIGH: begin
        if (I_tx_ready) begin
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Queue storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge I_clk_10M) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {I_awg_id, I_port, I_addr, I_delay};
    end
  end

  // State register, queue pointers, dwell counter and all registered outputs.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= {PW{1'b0}};
      r_rd_ptr    <= {PW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_cnt       <= 16'd0;
      r_wr_rdy    <= 1'b0;
      r_data      <= 64'd0;
      r_vld       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_tx_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_data   <= f_pack(r_mem[r_rd_ptr]);
      end
      r_count <= w_count_nxt;
      // Dwell counter restarts on every state change; only WAIT_LOW and GAP look at it.
      if (w_state_nxt != r_state) begin
        r_cnt <= 16'd0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_wr_rdy    <= (w_count_nxt != FULL_CNT);
      r_vld       <= w_fire;
      r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != {CW{1'b0}});
      r_frame_cnt <= r_frame_cnt + {15'd0, w_fire};
      r_tx_err    <= r_tx_err | w_timeout;
    end
  end

endmodule

// File: tb/tb_uart_delay_cmd_packer.sv
// Self-checking bench for uart_delay_cmd_packer: table of hand-computed
// frames, hand-written multi-cycle sequences, and a randomized run checked
// against a frame/queue reference model with a simple UART_TX_DATA stand-in.
module tb_uart_delay_cmd_packer;

  localparam int DEPTH = 4;
  localparam int GAP   = 20;
  localparam int ACK   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_vld;
  logic        wr_rdy;
  logic [4:0]  awg;
  logic [1:0]  port;
  logic [10:0] addr;
  logic [23:0] delay;
  logic [63:0] o_data;
  logic        o_vld;
  logic        tx_ready;
  logic        o_busy;
  logic [15:0] o_frame_cnt;
  logic        o_tx_err;

  uart_delay_cmd_packer #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .I_clk_10M      (clk),
    .I_rst          (rst),
    .I_wr_vld       (wr_vld),
    .O_wr_rdy       (wr_rdy),
    .I_awg_id       (awg),
    .I_port         (port),
    .I_addr         (addr),
    .I_delay        (delay),
    .O_UART_DATA    (o_data),
    .O_UART_DATA_VLD(o_vld),
    .I_tx_ready     (tx_ready),
    .O_busy         (o_busy),
    .O_frame_cnt    (o_frame_cnt),
    .O_tx_err       (o_tx_err)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [4:0]  awg;
    logic [1:0]  port;
    logic [10:0] addr;
    logic [23:0] delay;
    logic [63:0] exp;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          vld_cnt = 0;
  bit          uart_auto = 1'b0;
  int          uart_busy = 0;
  int          uart_len = 10;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int          vld_cyc_q[$];

  // Frame built from the field rules with byte arithmetic.
  function automatic logic [63:0] model_frame(logic [4:0] a, logic [1:0] p, logic [10:0] ad, logic [23:0] d);
    int b[7];
    int cks;
    int ai;
    int pi;
    int adi;
    int di;
    logic [63:0] f;
    ai = a; pi = p; adi = ad; di = d;
    b[0] = 165;
    b[1] = ai * 8 + pi * 2;
    b[2] = adi / 256;
    b[3] = adi % 256;
    b[4] = (di / 65536) % 256;
    b[5] = (di / 256) % 256;
    b[6] = di % 256;
    cks = 0;
    for (int i = 0; i < 7; i++) cks = cks ^ b[i];
    f = 64'd0;
    for (int i = 0; i < 4; i++) f = f * 64'd256 + 64'(b[i]);
    f = f * 64'd256 + 64'(cks);
    f = f * 64'd16777216 + 64'(di);
    return f;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; outputs observed on the falling edge, UART stand-in updated there.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (uart_auto && uart_busy > 0) begin
      uart_busy--;
      if (uart_busy == 0) tx_ready = 1'b1;
    end
    if (o_vld === 1'b1) begin
      got_q.push_back(o_data);
      vld_cyc_q.push_back(cyc);
      vld_cnt++;
      if (uart_auto) begin
        tx_ready  = 1'b0;
        uart_busy = uart_len;
      end
    end
  endtask

  task automatic set_req(logic [4:0] a, logic [1:0] p, logic [10:0] ad, logic [23:0] d);
    awg = a; port = p; addr = ad; delay = d;
  endtask

  task automatic push(logic [4:0] a, logic [1:0] p, logic [10:0] ad, logic [23:0] d);
    set_req(a, p, ad, d);
    wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
  endtask

  task automatic wait_vlds(int target, int bound, string name);
    int n;
    n = 0;
    while (vld_cnt < target && n < bound) begin
      tick();
      n++;
    end
    total++;
    if (vld_cnt < target) begin
      bad++;
      $display("FAIL %s: frames seen %0d expected %0d", name, vld_cnt, target);
    end
  endtask

  task automatic wait_idle(int bound, string name);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: busy still %b expected 0", name, o_busy);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_rdy"},  64'(wr_rdy),      64'd0);
    chk({tag, "_data"}, o_data,           64'd0);
    chk({tag, "_vld"},  64'(o_vld),       64'd0);
    chk({tag, "_busy"}, 64'(o_busy),      64'd0);
    chk({tag, "_cnt"},  64'(o_frame_cnt), 64'd0);
    chk({tag, "_err"},  64'(o_tx_err),    64'd0);
  endtask

  // Hard time limit in case a wait above is mis-bounded.
  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [63:0] e;
    logic [63:0] exp5[$];
    int          base;
    int          t_v;
    int          n;
    int          acc;

    vecs[0] = '{5'd14, 2'd0, 11'h000, 24'h00000A, 64'hA570_0000_DF00_000A};
    vecs[1] = '{5'd31, 2'd3, 11'h7FF, 24'hFFFFFF, 64'hA5FE_07FF_5CFF_FFFF};
    vecs[2] = '{5'd1,  2'd2, 11'h123, 24'h123456, 64'hA50C_0123_FB12_3456};
    vecs[3] = '{5'd0,  2'd1, 11'h400, 24'h000001, 64'hA502_0400_A200_0001};
    vecs[4] = '{5'd21, 2'd1, 11'h0AA, 24'hA5A5A5, 64'hA5AA_00AA_00A5_A5A5};

    rst = 1'b1; wr_vld = 1'b0; tx_ready = 1'b1;
    set_req(5'd0, 2'd0, 11'd0, 24'd0);

    // Reset values, then ready on the first cycle out of reset.
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 64'(wr_rdy), 64'd1);
    chk("busy_after_rst", 64'(o_busy), 64'd0);

    // Table of single writes: two-cycle latency, exact frame, one pulse each.
    uart_auto = 1'b1; uart_len = 10;
    for (int i = 0; i < 5; i++) begin
      base = vld_cnt;
      push(vecs[i].awg, vecs[i].port, vecs[i].addr, vecs[i].delay);
      tick();
      chk($sformatf("vec%0d_vld_early", i), 64'(o_vld), 64'd0);
      tick();
      chk($sformatf("vec%0d_vld_n2", i), 64'(o_vld), 64'd1);
      chk($sformatf("vec%0d_frame", i), o_data, vecs[i].exp);
      wait_idle(200, "vec_idle");
      chk($sformatf("vec%0d_pulses", i), 64'(vld_cnt - base), 64'd1);
      chk($sformatf("vec%0d_cnt", i), 64'(o_frame_cnt), 64'(i + 1));
    end

    // Four back-to-back writes: order, frames, exact frame-to-frame spacing.
    got_q.delete(); vld_cyc_q.delete(); base = vld_cnt;
    for (int p = 0; p < 4; p++) push(5'd14, 2'(p), 11'd0, 24'(10 * (p + 1)));
    wait_vlds(base + 4, 600, "b2b_frames");
    for (int p = 0; p < 4 && p < got_q.size(); p++)
      chk($sformatf("b2b_frame%0d", p), got_q[p], model_frame(5'd14, 2'(p), 11'd0, 24'(10 * (p + 1))));
    for (int p = 1; p < 4 && p < vld_cyc_q.size(); p++)
      chk($sformatf("b2b_gap%0d", p), 64'(vld_cyc_q[p] - vld_cyc_q[p-1]), 64'(uart_len + GAP + 3));
    wait_idle(200, "b2b_idle");
    chk("b2b_cnt", 64'(o_frame_cnt), 64'd9);

    // Five pushes while UART_TX_DATA stays busy: queue fills at four, fifth dropped.
    uart_auto = 1'b0; tx_ready = 1'b1; base = vld_cnt;
    push(5'd3, 2'd1, 11'd5, 24'd777);
    wait_vlds(base + 1, 20, "full_first");
    tx_ready = 1'b0;
    tick();
    exp5.delete();
    for (int k = 0; k < 5; k++) begin
      push(5'(k + 2), 2'(k), 11'(k * 100), 24'(1000 + k));
      if (k < 4) exp5.push_back(model_frame(5'(k + 2), 2'(k), 11'(k * 100), 24'(1000 + k)));
      chk($sformatf("full_rdy%0d", k), 64'(wr_rdy), (k >= 3) ? 64'd0 : 64'd1);
    end
    got_q.delete(); base = vld_cnt;
    uart_busy = 0; uart_auto = 1'b1; tx_ready = 1'b1;
    wait_vlds(base + 4, 600, "full_drain");
    repeat (150) tick();
    chk("full_sent", 64'(vld_cnt - base), 64'd4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      chk($sformatf("full_frame%0d", k), got_q[k], exp5[k]);
    wait_idle(200, "full_idle");
    chk("full_cnt", 64'(o_frame_cnt), 64'd14);

    // Stalled SEND: frame held stable, no strobe until ready rises, then one pulse.
    uart_auto = 1'b0; tx_ready = 1'b0; base = vld_cnt;
    e = model_frame(5'd9, 2'd2, 11'h3C3, 24'hC0FFEE);
    push(5'd9, 2'd2, 11'h3C3, 24'hC0FFEE);
    tick(); tick();
    chk("stall_load", o_data, e);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("stall_hold%0d", k), o_data, e);
    end
    chk("stall_novld", 64'(vld_cnt - base), 64'd0);
    uart_busy = 0; uart_auto = 1'b1; tx_ready = 1'b1;
    wait_idle(200, "stall_idle");
    chk("stall_pulses", 64'(vld_cnt - base), 64'd1);
    chk("stall_cnt", 64'(o_frame_cnt), 64'd15);

    // Ack timeout: ready never falls, error after ACK cycles, next frame still goes.
    chk("err_clear", 64'(o_tx_err), 64'd0);
    uart_auto = 1'b0; tx_ready = 1'b1; base = vld_cnt; got_q.delete();
    push(5'd7, 2'd0, 11'd1, 24'd11);
    push(5'd7, 2'd1, 11'd2, 24'd22);
    wait_vlds(base + 1, 20, "tmo_first");
    t_v = vld_cyc_q[$];
    n = 0;
    while (o_tx_err !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_latency", 64'(cyc - t_v), 64'(ACK));
    wait_vlds(base + 2, 200, "tmo_second");
    if (got_q.size() >= 2) chk("tmo_frame2", got_q[1], model_frame(5'd7, 2'd1, 11'd2, 24'd22));
    wait_idle(200, "tmo_idle");
    chk("tmo_sticky", 64'(o_tx_err), 64'd1);
    chk("tmo_cnt", 64'(o_frame_cnt), 64'd17);

    // Reset in WAIT_HIGH with two queued: everything back to reset values, nothing sent.
    tx_ready = 1'b1; base = vld_cnt;
    push(5'd4, 2'd3, 11'd9, 24'd99);
    wait_vlds(base + 1, 20, "rst_first");
    tx_ready = 1'b0;
    tick();
    push(5'd5, 2'd0, 11'd1, 24'd1);
    push(5'd6, 2'd1, 11'd2, 24'd2);
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();
    chk("midrst_rdy_after", 64'(wr_rdy), 64'd1);
    base = vld_cnt;
    uart_busy = 0; uart_auto = 1'b1; tx_ready = 1'b1;
    repeat (80) tick();
    chk("midrst_novld", 64'(vld_cnt - base), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);

    // Randomized traffic against the reference model.
    got_q.delete(); exp_q.delete(); acc = 0; base = vld_cnt;
    for (int c = 0; c < 1500; c++) begin
      uart_len = $urandom_range(1, 12);
      if ($urandom_range(0, 3) == 0) begin
        set_req(5'($urandom), 2'($urandom), 11'($urandom), 24'($urandom));
        wr_vld = 1'b1;
      end else begin
        wr_vld = 1'b0;
      end
      if (acc - (vld_cnt - base) < DEPTH) chk("rnd_rdy", 64'(wr_rdy), 64'd1);
      if (wr_vld && wr_rdy) begin
        exp_q.push_back(model_frame(awg, port, addr, delay));
        acc++;
      end
      tick();
    end
    wr_vld = 1'b0;
    wait_vlds(base + acc, 6000, "rnd_drain");
    wait_idle(200, "rnd_idle");
    chk("rnd_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("rnd_frame%0d", k), got_q[k], exp_q[k]);
    chk("rnd_frame_cnt", 64'(o_frame_cnt), 64'(acc));
    chk("rnd_err", 64'(o_tx_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
